// File: rtl/reg_comp.sv
// reg_comp - register file for the 16-bit datapath.
//
// Sixteen 16-bit general registers. Register 0 is hardwired to zero.
// Read and write selects come directly from fields of the instruction word.
//
// Ports:
//   CLK        system clock; every state change happens on the rising edge
//   Reset      synchronous, active-high; clears every register
//   IR[15:0]   instruction word
//                [15:12] opcode (ignored here)
//                [11:8]  A-read select
//                [7:4]   B-read select
//                [3:0]   C-read select and write select
//   RegWrite   write enable, sampled on the rising edge
//   writedata  value written to register IR[3:0]
//   A, B, C    combinational read ports for registers IR[11:8], IR[7:4], IR[3:0]
//
// Reads are purely combinational and have no write bypass. A register
// written on an edge shows its old value up to that edge and the new value
// immediately after it.
module reg_comp #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 16
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic [15:0]           IR,
  input  logic                  RegWrite,
  input  logic [DATA_WIDTH-1:0] writedata,
  output logic [DATA_WIDTH-1:0] A,
  output logic [DATA_WIDTH-1:0] B,
  output logic [DATA_WIDTH-1:0] C
);

  localparam int SEL_WIDTH = $clog2(NUM_REGS);

  logic [SEL_WIDTH-1:0]  asel;
  logic [SEL_WIDTH-1:0]  bsel;
  logic [SEL_WIDTH-1:0]  csel;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // The opcode field is not needed here. It is folded into a deliberately
  // unused net so the lint does not flag it as forgotten.
  logic unused_opcode;
  assign unused_opcode = ^IR[15:12];

  assign asel = IR[11:8];
  assign bsel = IR[7:4];
  assign csel = IR[3:0];

  // Reset takes priority over a write on the same edge. A write to
  // register 0 is dropped here. The read muxes also force zero for index 0,
  // so register 0 reads 0x0000 even before the first reset.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (RegWrite && (csel != '0)) begin
      regs[csel] <= writedata;
    end
  end

  always_comb begin
    A = '0;
    B = '0;
    C = '0;
    if (asel != '0) A = regs[asel];
    if (bsel != '0) B = regs[bsel];
    if (csel != '0) C = regs[csel];
  end

endmodule

// File: tb/tb_reg_comp.sv
// tb_reg_comp - scoreboard testbench for reg_comp.
//
// The stimulus process drives one set of inputs per cycle, shortly after
// the rising edge. For each cycle it checks, it pushes the expected A/B/C
// values, which a reference register-array model computes. A separate
// monitor pops one entry at each falling edge and compares it with the DUT
// ports, so every read is taken before the next write edge.
module tb_reg_comp;

  logic        CLK;
  logic        Reset;
  logic [15:0] IR;
  logic        RegWrite;
  logic [15:0] writedata;
  logic [15:0] A;
  logic [15:0] B;
  logic [15:0] C;

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] model [16];
  int          checks = 0;
  int          errors = 0;

  reg_comp dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .IR       (IR),
    .RegWrite (RegWrite),
    .writedata(writedata),
    .A        (A),
    .B        (B),
    .C        (C)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [15:0] modelRead(input logic [3:0] sel);
    if (sel == 4'd0) return 16'h0000;
    return model[sel];
  endfunction

  // Drives one cycle of inputs. The expected reads reflect the register
  // contents before the coming edge. The model then takes that edge.
  task automatic applyStimulus(input logic rst, input logic rw,
                               input logic [15:0] ir, input logic [15:0] wd,
                               input bit chk, input string name);
    exp_t e;
    @(posedge CLK);
    #1;
    Reset     = rst;
    RegWrite  = rw;
    IR        = ir;
    writedata = wd;
    if (chk) begin
      e.name = name;
      e.a    = modelRead(ir[11:8]);
      e.b    = modelRead(ir[7:4]);
      e.c    = modelRead(ir[3:0]);
      sb.push_back(e);
    end
    if (rst) begin
      for (int i = 0; i < 16; i++) model[i] = 16'h0000;
    end else if (rw && ir[3:0] != 4'd0) begin
      model[ir[3:0]] = wd;
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checks += 3;
    if (A !== e.a) begin
      errors++;
      $display("[TB] FAIL %s port A: got %h expected %h (IR=%h)", e.name, A, e.a, IR);
    end
    if (B !== e.b) begin
      errors++;
      $display("[TB] FAIL %s port B: got %h expected %h (IR=%h)", e.name, B, e.b, IR);
    end
    if (C !== e.c) begin
      errors++;
      $display("[TB] FAIL %s port C: got %h expected %h (IR=%h)", e.name, C, e.c, IR);
    end
  endtask

  always @(negedge CLK) begin
    if (sb.size() > 0) checkOutput(sb.pop_front());
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] base;
    Reset     = 1'b1;
    RegWrite  = 1'b0;
    IR        = 16'h0000;
    writedata = 16'h0000;
    for (int i = 0; i < 16; i++) model[i] = 16'h0000;

    applyStimulus(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, "reset");
    applyStimulus(1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b1, "reset_all15");
    applyStimulus(1'b0, 1'b0, 16'h1234, 16'h0000, 1'b1, "reset_mixed");

    applyStimulus(1'b0, 1'b1, 16'h0120, 16'h000F, 1'b0, "wr_reg0");
    applyStimulus(1'b0, 1'b0, 16'h0012, 16'h0000, 1'b1, "reg0_discard");

    applyStimulus(1'b0, 1'b1, 16'h0201, 16'h00F0, 1'b0, "wr_reg1");
    applyStimulus(1'b0, 1'b1, 16'h0012, 16'h0F00, 1'b0, "wr_reg2");
    applyStimulus(1'b0, 1'b0, 16'h0012, 16'h0000, 1'b1, "read_012");

    for (int g = 0; g < 4; g++) begin
      base = 4'(3 + 3 * g);
      applyStimulus(1'b0, 1'b1, {12'h000, base},        16'h000F, 1'b0, "sweep_wr");
      applyStimulus(1'b0, 1'b1, {12'h000, base + 4'd1}, 16'h00F0, 1'b0, "sweep_wr");
      applyStimulus(1'b0, 1'b1, {12'h000, base + 4'd2}, 16'h0F00, 1'b0, "sweep_wr");
      applyStimulus(1'b0, 1'b0, {4'h0, base, base + 4'd1, base + 4'd2}, 16'h0000, 1'b1, "sweep_rd");
    end

    applyStimulus(1'b0, 1'b1, 16'h0FFF, 16'hFFFF, 1'b0, "wr_reg15");
    applyStimulus(1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b1, "read_fff");

    applyStimulus(1'b0, 1'b0, 16'h0003, 16'h1234, 1'b1, "nowrite_pre");
    applyStimulus(1'b0, 1'b0, 16'h0003, 16'h0000, 1'b1, "nowrite_post");

    applyStimulus(1'b0, 1'b1, 16'h0555, 16'hBEEF, 1'b1, "bypass_old");
    applyStimulus(1'b0, 1'b0, 16'h0555, 16'h0000, 1'b1, "bypass_new");

    applyStimulus(1'b1, 1'b1, 16'h0007, 16'hAAAA, 1'b0, "reset_vs_write");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b0, {4'hA, 4'(i), 4'(15 - i), 4'(i)}, 16'h0000, 1'b1, "post_reset");
    end

    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(0, 49) == 0), 1'($urandom),
                    16'($urandom), 16'($urandom), 1'b1, "random");
    end

    for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge CLK);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
